// File: rtl/frame_rd_ctrl_pkg.sv
// Shared definitions for the frame-buffer read controller: state encoding,
// default burst geometry and the burst-length helper.
package frame_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  localparam int DEF_BURST_LEN     = 64;
  localparam int DEF_BYTES_PER_PIX = 4;

  // Wide enough for a full 4095 x 4095 frame pixel count.
  localparam int REMAIN_W = 25;

  function automatic logic [7:0] burst_len_of(input logic [REMAIN_W-1:0] remaining,
                                               input int max_len);
    if (remaining > REMAIN_W'(max_len))
      return 8'(max_len);
    else
      return remaining[7:0];
  endfunction

endpackage

// File: rtl/frame_rd_ctrl_frame_sync.sv
// frame_sync: brings the display-domain frame_start level into wr_clk with a
// two-flop synchronizer and turns its rising edge into a one-cycle pulse.
module frame_sync (
  input  logic wr_clk,
  input  logic rst,
  input  logic frame_start,
  output logic fs_pulse
);

  logic sync_q1;
  logic sync_q2;
  logic sync_prev;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_q1   <= frame_start;
      sync_q2   <= sync_q1;
      sync_prev <= sync_q2;
    end
  end

  assign fs_pulse = sync_q2 & ~sync_prev;

endmodule

// File: rtl/frame_rd_ctrl.sv
// Frame-buffer read controller: walks a frame in memory bursts on demand of
// the display FIFO and forwards the returned RGB888 pixels into that FIFO.
module frame_rd_ctrl
  import frame_rd_ctrl_pkg::*;
#(
  parameter int                ADDR_W        = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int                BURST_LEN     = DEF_BURST_LEN,
  parameter int                BYTES_PER_PIX = DEF_BYTES_PER_PIX
) (
  input  logic              rst,
  input  logic              wr_clk,
  input  logic              frame_start,
  input  logic              fifo_in_req,
  input  logic [11:0]       Hh,
  input  logic [11:0]       Vv,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [7:0]        mem_rd_len,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  output logic              fifo_wr_en,
  output logic [23:0]       fifo_wdata,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PIX_STRIDE = ADDR_W'(BYTES_PER_PIX);

  state_t              state;
  state_t              state_nxt;
  logic [REMAIN_W-1:0] remaining;
  logic [REMAIN_W-1:0] remaining_nxt;
  logic [REMAIN_W-1:0] frame_total;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [7:0]          len;
  logic [7:0]          len_nxt;
  logic [7:0]          beat_cnt;
  logic [7:0]          beat_cnt_nxt;
  logic                restart_pend;
  logic                restart_pend_nxt;
  logic                frame_done_nxt;
  logic                beat_accept;
  logic                fs_pulse;
  logic [7:0]          unused_data_hi;

  frame_sync u_frame_sync (
    .wr_clk      (wr_clk),
    .rst         (rst),
    .frame_start (frame_start),
    .fs_pulse    (fs_pulse)
  );

  assign unused_data_hi = mem_rd_data[31:24];
  assign frame_total    = REMAIN_W'(Hh) * REMAIN_W'(Vv);

  assign mem_rd_req  = (state == ST_REQ);
  assign busy        = (state != ST_IDLE);
  assign mem_rd_addr = addr;
  assign mem_rd_len  = len;

  // A restart relatches the frame size and address; a burst that memory has
  // already accepted is always drained first, so the DATA case defers it.
  always_comb begin
    state_nxt        = state;
    remaining_nxt    = remaining;
    addr_nxt         = addr;
    len_nxt          = len;
    beat_cnt_nxt     = beat_cnt;
    restart_pend_nxt = restart_pend;
    frame_done_nxt   = 1'b0;
    beat_accept      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (fs_pulse && (Hh != '0) && (Vv != '0)) begin
          remaining_nxt = frame_total;
          addr_nxt      = BASE_ADDR;
          state_nxt     = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (fs_pulse) begin
          remaining_nxt = frame_total;
          addr_nxt      = BASE_ADDR;
        end else if (remaining == '0) begin
          frame_done_nxt = 1'b1;
          state_nxt      = ST_IDLE;
        end else if (fifo_in_req) begin
          len_nxt   = burst_len_of(remaining, BURST_LEN);
          state_nxt = ST_REQ;
        end
      end

      ST_REQ: begin
        if (mem_rd_ack) begin
          beat_cnt_nxt     = len;
          restart_pend_nxt = fs_pulse;
          state_nxt        = ST_DATA;
        end else if (fs_pulse) begin
          remaining_nxt = frame_total;
          addr_nxt      = BASE_ADDR;
          state_nxt     = ST_CHECK;
        end
      end

      ST_DATA: begin
        if (fs_pulse)
          restart_pend_nxt = 1'b1;
        if (mem_rd_valid) begin
          beat_accept  = 1'b1;
          beat_cnt_nxt = beat_cnt - 8'd1;
          if (beat_cnt == 8'd1) begin
            if (restart_pend || fs_pulse) begin
              remaining_nxt    = frame_total;
              addr_nxt         = BASE_ADDR;
              restart_pend_nxt = 1'b0;
            end else begin
              addr_nxt      = addr + ADDR_W'(len) * PIX_STRIDE;
              remaining_nxt = remaining - REMAIN_W'(len);
            end
            state_nxt = ST_CHECK;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      remaining    <= '0;
      addr         <= BASE_ADDR;
      len          <= '0;
      beat_cnt     <= '0;
      restart_pend <= 1'b0;
      frame_done   <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wdata   <= '0;
    end else begin
      remaining    <= remaining_nxt;
      addr         <= addr_nxt;
      len          <= len_nxt;
      beat_cnt     <= beat_cnt_nxt;
      restart_pend <= restart_pend_nxt;
      frame_done   <= frame_done_nxt;
      fifo_wr_en   <= beat_accept;
      if (beat_accept)
        fifo_wdata <= mem_rd_data[23:0];
    end
  end

endmodule

// File: tb/tb_frame_rd_ctrl.sv
// Self-checking bench for frame_rd_ctrl: a bench-side memory responder drives
// bursts while the expected burst list and pixel stream come from the frame size.
module tb_frame_rd_ctrl;

  localparam int                ADDR_W = 28;
  localparam logic [ADDR_W-1:0] BASE   = '0;
  localparam int                BL     = 4;
  localparam int                BPP    = 4;

  logic              rst;
  logic              wr_clk;
  logic              frame_start;
  logic              fifo_in_req;
  logic [11:0]       Hh;
  logic [11:0]       Vv;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_len;
  logic              mem_rd_ack;
  logic              mem_rd_valid;
  logic [31:0]       mem_rd_data;
  logic              fifo_wr_en;
  logic [23:0]       fifo_wdata;
  logic              frame_done;
  logic              busy;

  frame_rd_ctrl #(
    .ADDR_W        (ADDR_W),
    .BASE_ADDR     (BASE),
    .BURST_LEN     (BL),
    .BYTES_PER_PIX (BPP)
  ) dut (
    .rst          (rst),
    .wr_clk       (wr_clk),
    .frame_start  (frame_start),
    .fifo_in_req  (fifo_in_req),
    .Hh           (Hh),
    .Vv           (Vv),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_len   (mem_rd_len),
    .mem_rd_ack   (mem_rd_ack),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wdata   (fifo_wdata),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int                n_cmp = 0;
  int                n_err = 0;
  int                done_cnt = 0;
  logic [23:0]       wr_q[$];
  logic [23:0]       sent_q[$];
  logic [ADDR_W-1:0] bq_addr[$];
  logic [7:0]        bq_len[$];

  // Every cycle advance goes through here; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge wr_clk);
    #1;
    if (fifo_wr_en === 1'b1) wr_q.push_back(fifo_wdata);
    if (frame_done === 1'b1) done_cnt++;
  endtask

  task automatic clear_logs();
    wr_q.delete();
    sent_q.delete();
    bq_addr.delete();
    bq_len.delete();
  endtask

  task automatic start_frame(input int hold);
    frame_start = 1'b1;
    repeat (hold) tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = (mem_rd_req === 1'b1);
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = (mem_rd_req === 1'b1);
    end
  endtask

  task automatic accept_burst(output int n);
    bq_addr.push_back(mem_rd_addr);
    bq_len.push_back(mem_rd_len);
    n = int'(mem_rd_len);
    mem_rd_ack = 1'b1;
    tick();
    mem_rd_ack = 1'b0;
  endtask

  task automatic send_beats(input int n, input int gap_pct);
    int sent = 0;
    while (sent < n) begin
      if ($urandom_range(99) >= gap_pct) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = $urandom;
        sent_q.push_back(mem_rd_data[23:0]);
        sent++;
      end
      tick();
      mem_rd_valid = 1'b0;
    end
  endtask

  task automatic serve_frame(input int ack_delay, input int gap_pct, input int req_pct,
                             input int budget, output bit ok);
    int d0  = done_cnt;
    int cyc = 0;
    int n;
    ok = 1'b0;
    while (cyc < budget) begin
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      fifo_in_req = ($urandom_range(99) < req_pct);
      if (mem_rd_req === 1'b1) begin
        repeat (ack_delay) begin
          tick();
          cyc++;
        end
        accept_burst(n);
        send_beats(n, gap_pct);
        cyc += n + 1;
      end else begin
        tick();
        cyc++;
      end
    end
    fifo_in_req = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    if (mem_rd_req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req: got %b expected 0", mem_rd_req); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (fifo_wr_en !== 1'b0 || fifo_wdata !== 24'd0) begin
      n_err++; $display("[TB] FAIL reset_fifo: got en=%b data=%h expected 0/0", fifo_wr_en, fifo_wdata);
    end
    n_cmp++;
    if (mem_rd_addr !== BASE || mem_rd_len !== 8'd0) begin
      n_err++; $display("[TB] FAIL reset_addr_len: got %h/%0d expected %h/0", mem_rd_addr, mem_rd_len, BASE);
    end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b expected 0", frame_done); end
    n_cmp++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame(input string name, input int h, input int v, input int ack_delay,
                            input int gap_pct, input int req_pct, input bit change_dims);
    int                n = h * v;
    int                exp_bursts = (n + BL - 1) / BL;
    int                rem;
    int                d0 = done_cnt;
    bit                ok;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_len;
    clear_logs();
    Hh = 12'(h);
    Vv = 12'(v);
    fifo_in_req = 1'b1;
    start_frame(3);
    if (change_dims) begin
      Hh = 12'($urandom_range(1, 4095));
      Vv = 12'($urandom_range(1, 4095));
    end
    serve_frame(ack_delay, gap_pct, req_pct, 3000, ok);
    if (!ok) begin n_err++; $display("[TB] FAIL %s_timeout: frame_done not seen, expected within 3000 cycles", name); end
    n_cmp++;
    if (bq_addr.size() != exp_bursts) begin
      n_err++; $display("[TB] FAIL %s_burst_count: got %0d expected %0d", name, bq_addr.size(), exp_bursts);
    end
    n_cmp++;
    for (int k = 0; k < bq_addr.size() && k < exp_bursts; k++) begin
      rem      = n - k * BL;
      exp_addr = BASE + ADDR_W'(k * BL * BPP);
      exp_len  = 8'((rem < BL) ? rem : BL);
      if (bq_addr[k] !== exp_addr || bq_len[k] !== exp_len) begin
        n_err++;
        $display("[TB] FAIL %s_burst%0d: got addr=%h len=%0d expected addr=%h len=%0d",
                 name, k, bq_addr[k], bq_len[k], exp_addr, exp_len);
      end
      n_cmp++;
    end
    if (wr_q.size() != n) begin
      n_err++; $display("[TB] FAIL %s_write_count: got %0d expected %0d", name, wr_q.size(), n);
    end
    n_cmp++;
    for (int i = 0; i < wr_q.size() && i < sent_q.size(); i++) begin
      if (wr_q[i] !== sent_q[i]) begin
        n_err++; $display("[TB] FAIL %s_pixel%0d: got %h expected %h", name, i, wr_q[i], sent_q[i]);
      end
      n_cmp++;
    end
    repeat (3) tick();
    if (done_cnt - d0 != 1) begin
      n_err++; $display("[TB] FAIL %s_done_pulses: got %0d expected 1", name, done_cnt - d0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL %s_idle: got busy=%b expected 0", name, busy); end
    n_cmp++;
  endtask

  task automatic test_fifo_hold();
    bit seen = 1'b0;
    bit ok;
    clear_logs();
    Hh = 12'd4;
    Vv = 12'd1;
    fifo_in_req = 1'b0;
    start_frame(3);
    repeat (20) begin
      tick();
      if (mem_rd_req !== 1'b0) seen = 1'b1;
    end
    if (seen) begin n_err++; $display("[TB] FAIL hold_no_req: got req while fifo_in_req=0, expected none"); end
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL hold_busy: got %b expected 1", busy); end
    n_cmp++;
    fifo_in_req = 1'b1;
    tick();
    if (mem_rd_req !== 1'b1) begin n_err++; $display("[TB] FAIL hold_req_next: got %b expected 1", mem_rd_req); end
    n_cmp++;
    serve_frame(0, 0, 100, 200, ok);
    if (!ok || wr_q.size() != 4) begin
      n_err++; $display("[TB] FAIL hold_finish: got done=%b writes=%0d expected 1/4", ok, wr_q.size());
    end
    n_cmp++;
  endtask

  task automatic test_ack_delay();
    bit ok;
    int n;
    clear_logs();
    Hh = 12'd4;
    Vv = 12'd1;
    fifo_in_req = 1'b1;
    start_frame(3);
    wait_req(20, ok);
    if (!ok) begin n_err++; $display("[TB] FAIL ackdly_req_timeout: no request, expected one within 20 cycles"); end
    n_cmp++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_rd_req !== 1'b1 || mem_rd_addr !== BASE || mem_rd_len !== 8'd4) begin
        n_err++;
        $display("[TB] FAIL ackdly_hold%0d: got req=%b addr=%h len=%0d expected 1/%h/4",
                 i, mem_rd_req, mem_rd_addr, mem_rd_len, BASE);
      end
      n_cmp++;
    end
    accept_burst(n);
    send_beats(n, 0);
    serve_frame(0, 0, 100, 100, ok);
    if (!ok || bq_addr.size() != 1) begin
      n_err++; $display("[TB] FAIL ackdly_bursts: got done=%b bursts=%0d expected 1/1", ok, bq_addr.size());
    end
    n_cmp++;
    if (wr_q.size() != 4 || wr_q != sent_q) begin
      n_err++; $display("[TB] FAIL ackdly_writes: got %0d matching=%b expected 4/1", wr_q.size(), wr_q == sent_q);
    end
    n_cmp++;
  endtask

  // same_cycle=1 lines the synchronized pulse up with the final beat of the burst.
  task automatic test_restart_in_data(input bit same_cycle);
    bit ok;
    int n;
    int d0 = done_cnt;
    clear_logs();
    Hh = 12'd8;
    Vv = 12'd1;
    fifo_in_req = 1'b1;
    start_frame(3);
    wait_req(20, ok);
    accept_burst(n);
    if (same_cycle) begin
      send_beats(3, 0);
      frame_start = 1'b1;
      tick();
      tick();
      send_beats(1, 0);
      frame_start = 1'b0;
    end else begin
      send_beats(2, 0);
      start_frame(5);
      if (busy !== 1'b1 || mem_rd_req !== 1'b0) begin
        n_err++; $display("[TB] FAIL rsdata_still_data: got busy=%b req=%b expected 1/0", busy, mem_rd_req);
      end
      n_cmp++;
      send_beats(2, 0);
    end
    if (wr_q.size() != 4) begin
      n_err++; $display("[TB] FAIL rsdata%0d_burst_done: got %0d writes expected 4", same_cycle, wr_q.size());
    end
    n_cmp++;
    wait_req(10, ok);
    if (!ok || mem_rd_addr !== BASE || mem_rd_len !== 8'd4) begin
      n_err++;
      $display("[TB] FAIL rsdata%0d_restart_req: got ok=%b addr=%h len=%0d expected 1/%h/4",
               same_cycle, ok, mem_rd_addr, mem_rd_len, BASE);
    end
    n_cmp++;
    serve_frame(0, 0, 100, 300, ok);
    if (!ok || wr_q.size() != 12 || wr_q != sent_q) begin
      n_err++;
      $display("[TB] FAIL rsdata%0d_frame: got done=%b writes=%0d expected 1/12 matching", same_cycle, ok, wr_q.size());
    end
    n_cmp++;
    if (bq_addr.size() != 3 || bq_addr[2] !== BASE + ADDR_W'(16)) begin
      n_err++; $display("[TB] FAIL rsdata%0d_bursts: got %0d bursts expected 3 ending at +16", same_cycle, bq_addr.size());
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_err++; $display("[TB] FAIL rsdata%0d_done: got %0d pulses expected 1", same_cycle, done_cnt - d0);
    end
    n_cmp++;
  endtask

  task automatic test_restart_in_req();
    bit ok;
    int n;
    clear_logs();
    Hh = 12'd8;
    Vv = 12'd1;
    fifo_in_req = 1'b1;
    start_frame(3);
    wait_req(20, ok);
    accept_burst(n);
    send_beats(n, 0);
    wait_req(10, ok);
    if (!ok || mem_rd_addr !== BASE + ADDR_W'(16)) begin
      n_err++; $display("[TB] FAIL rsreq_second: got ok=%b addr=%h expected 1/%h", ok, mem_rd_addr, BASE + ADDR_W'(16));
    end
    n_cmp++;
    start_frame(3);
    if (mem_rd_req !== 1'b0) begin n_err++; $display("[TB] FAIL rsreq_drop: got req=%b expected 0", mem_rd_req); end
    n_cmp++;
    wait_req(10, ok);
    if (!ok || mem_rd_addr !== BASE || mem_rd_len !== 8'd4) begin
      n_err++; $display("[TB] FAIL rsreq_restart: got ok=%b addr=%h len=%0d expected 1/%h/4", ok, mem_rd_addr, mem_rd_len, BASE);
    end
    n_cmp++;
    serve_frame(0, 0, 100, 300, ok);
    if (!ok || wr_q.size() != 12 || bq_addr.size() != 3) begin
      n_err++; $display("[TB] FAIL rsreq_frame: got done=%b writes=%0d bursts=%0d expected 1/12/3", ok, wr_q.size(), bq_addr.size());
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int n;
    Hh = 12'd8;
    Vv = 12'd1;
    fifo_in_req = 1'b1;
    start_frame(3);
    wait_req(20, ok);
    accept_burst(n);
    send_beats(1, 0);
    rst = 1'b1;
    #1;
    if (fifo_wr_en !== 1'b0 || busy !== 1'b0 || mem_rd_req !== 1'b0 || fifo_wdata !== 24'd0) begin
      n_err++; $display("[TB] FAIL rstmid_immediate: got en=%b busy=%b req=%b data=%h expected 0/0/0/0",
                        fifo_wr_en, busy, mem_rd_req, fifo_wdata);
    end
    n_cmp++;
    tick();
    rst = 1'b0;
    clear_logs();
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hFFAB_CDEF;
    tick();
    tick();
    mem_rd_valid = 1'b0;
    repeat (3) tick();
    if (wr_q.size() != 0) begin n_err++; $display("[TB] FAIL rstmid_stray: got %0d writes expected 0", wr_q.size()); end
    n_cmp++;
    if (busy !== 1'b0 || mem_rd_addr !== BASE || mem_rd_len !== 8'd0 || fifo_wdata !== 24'd0) begin
      n_err++; $display("[TB] FAIL rstmid_outputs: got busy=%b addr=%h len=%0d data=%h expected 0/%h/0/0",
                        busy, mem_rd_addr, mem_rd_len, fifo_wdata, BASE);
    end
    n_cmp++;
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 6; it++)
      test_frame($sformatf("rand%0d", it), $urandom_range(1, 13), $urandom_range(1, 3),
                 $urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(50, 100), 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    frame_start  = 1'b0;
    fifo_in_req  = 1'b0;
    Hh           = '0;
    Vv           = '0;
    mem_rd_ack   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    test_reset();
    test_frame("frame8x2", 8, 2, 0, 0, 100, 1'b0);
    test_frame("frame10x1", 10, 1, 0, 0, 100, 1'b0);
    test_fifo_hold();
    test_ack_delay();
    test_restart_in_data(1'b0);
    test_restart_in_data(1'b1);
    test_restart_in_req();
    test_reset_mid_burst();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at 500us, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
